// File: rtl/simd_rf_pkg.sv
// Shared types and address helpers for the SIMD scalar/vector register file.
package simd_rf_pkg;

   localparam int ELEM_W_DEF = 32;
   localparam int LANES_DEF  = 4;

   typedef logic [LANES_DEF-1:0][ELEM_W_DEF-1:0] lane_vec_t;

   // Bit aw of a register address selects the scalar bank.
   function automatic logic is_scalar(input logic [15:0] addr, input logic [3:0] aw);
      return addr[aw];
   endfunction

   // Register index within its bank: the address with the bank bit stripped.
   function automatic logic [15:0] reg_idx(input logic [15:0] addr, input logic [3:0] aw);
      return addr & ((16'd1 << aw) - 16'd1);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: decode stall (RAW/WAW), outstanding count, writeback error pulse.
module rf_scoreboard
   import simd_rf_pkg::*;
#(
   parameter int NUM_VEC = 8,
   parameter int NUM_SC  = 16,
   parameter int SC_ZERO = 1,
   parameter int AW      = $clog2((NUM_VEC > NUM_SC) ? NUM_VEC : NUM_SC),
   parameter int CNT_W   = $clog2(NUM_VEC + NUM_SC + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_en1,
   input  logic             rd_en2,
   input  logic [AW:0]      rd_addr1,
   input  logic [AW:0]      rd_addr2,
   input  logic             rsv_valid,
   input  logic [AW:0]      rsv_addr,
   input  logic             wb_valid,
   input  logic [AW:0]      wb_addr,
   output logic             stall,
   output logic [CNT_W-1:0] pending_cnt,
   output logic             wb_err
);

   localparam int         NR  = NUM_VEC + NUM_SC;
   localparam logic [3:0] AW4 = 4'(AW);

   // One-hot selector of the busy bit behind an address; all-zero for an
   // unimplemented index or a hard-wired zero s0, so those are never busy.
   function automatic logic [NR-1:0] reg_sel(input logic [AW:0] addr);
      logic [NR-1:0] sel;
      logic [15:0]   ext;
      logic [15:0]   idx;
      logic          sc;
      ext = 16'(addr);
      sc  = is_scalar(ext, AW4);
      idx = reg_idx(ext, AW4);
      for (int r = 0; r < NUM_VEC; r++) begin
         sel[r] = ~sc & (idx == 16'(r));
      end
      for (int r = 0; r < NUM_SC; r++) begin
         sel[NUM_VEC + r] = sc & (idx == 16'(r)) & ~((SC_ZERO != 0) && (r == 0));
      end
      return sel;
   endfunction

   logic [NR-1:0]    busy_q;
   logic [NR-1:0]    busy_d;
   logic [CNT_W-1:0] pending_cnt_q;
   logic [CNT_W-1:0] pending_cnt_d;
   logic             wb_err_q;
   logic             wb_err_d;

   logic [NR-1:0]    rd1_sel;
   logic [NR-1:0]    rd2_sel;
   logic [NR-1:0]    rsv_sel;
   logic [NR-1:0]    wb_sel;
   logic [NR-1:0]    wb_clr;
   logic [NR-1:0]    rsv_set;
   logic [NR-1:0]    busy_eff;
   logic             stall_c;
   logic             rsv_acc;

   // Hazard check against busy bits (a register being written back this cycle is
   // served by the bypass), then next-state busy bits, count and error flag.
   always_comb begin
      rd1_sel = reg_sel(rd_addr1);
      rd2_sel = reg_sel(rd_addr2);
      rsv_sel = reg_sel(rsv_addr);
      wb_sel  = reg_sel(wb_addr);

      if (wb_valid) begin
         wb_clr = wb_sel;
      end else begin
         wb_clr = '0;
      end
      busy_eff = busy_q & ~wb_clr;

      stall_c = (rd_en1    & (|(busy_eff & rd1_sel))) |
                (rd_en2    & (|(busy_eff & rd2_sel))) |
                (rsv_valid & (|(busy_eff & rsv_sel)));

      rsv_acc = rsv_valid & ~stall_c;
      if (rsv_acc) begin
         rsv_set = rsv_sel;
      end else begin
         rsv_set = '0;
      end

      // Clear first, then set: a same-edge reservation wins over the writeback.
      busy_d = (busy_q & ~wb_clr) | rsv_set;

      pending_cnt_d = '0;
      for (int r = 0; r < NR; r++) begin
         pending_cnt_d = pending_cnt_d + CNT_W'(busy_d[r]);
      end

      wb_err_d = wb_valid & ~(|(busy_q & wb_sel));
   end

   // Scoreboard state with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q        <= '0;
         pending_cnt_q <= '0;
         wb_err_q      <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         pending_cnt_q <= pending_cnt_d;
         wb_err_q      <= wb_err_d;
      end
   end

   assign stall       = stall_c;
   assign pending_cnt = pending_cnt_q;
   assign wb_err      = wb_err_q;

endmodule

// File: rtl/simd_reg_file_sb.sv
// Scalar/vector register file with write bypass, masked vector writes and a hazard scoreboard.
module simd_reg_file_sb
   import simd_rf_pkg::*;
#(
   parameter int ELEM_W  = ELEM_W_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int NUM_VEC = 8,
   parameter int NUM_SC  = 16,
   parameter int SC_ZERO = 1,
   parameter int AW      = $clog2((NUM_VEC > NUM_SC) ? NUM_VEC : NUM_SC)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   rd_en1,
   input  logic                                   rd_en2,
   input  logic [AW:0]                            rd_addr1,
   input  logic [AW:0]                            rd_addr2,
   output logic [LANES*ELEM_W-1:0]                rd_data1,
   output logic [LANES*ELEM_W-1:0]                rd_data2,
   input  logic                                   rsv_valid,
   input  logic [AW:0]                            rsv_addr,
   input  logic                                   wb_valid,
   input  logic [AW:0]                            wb_addr,
   input  logic [LANES-1:0]                       wb_mask,
   input  logic [LANES*ELEM_W-1:0]                wb_data,
   output logic                                   stall,
   output logic [$clog2(NUM_VEC+NUM_SC+1)-1:0]    pending_cnt,
   output logic                                   wb_err
);

   localparam int          CNT_W = $clog2(NUM_VEC + NUM_SC + 1);
   localparam int          VIW   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int          SIW   = (NUM_SC > 1) ? $clog2(NUM_SC) : 1;
   localparam logic [3:0]  AW4   = 4'(AW);
   localparam logic [15:0] NV16  = 16'(NUM_VEC);
   localparam logic [15:0] NS16  = 16'(NUM_SC);

   typedef logic [LANES-1:0][ELEM_W-1:0] lanes_t;

   // Address decodes to a real vector register.
   function automatic logic vec_impl(input logic [AW:0] addr);
      logic [15:0] ext;
      ext = 16'(addr);
      return ~is_scalar(ext, AW4) & (reg_idx(ext, AW4) < NV16);
   endfunction

   // Address decodes to a real, writable scalar register (s0 excluded when hard-wired to zero).
   function automatic logic sc_impl(input logic [AW:0] addr);
      logic [15:0] ext;
      logic [15:0] idx;
      ext = 16'(addr);
      idx = reg_idx(ext, AW4);
      return is_scalar(ext, AW4) & (idx < NS16) & ~((SC_ZERO != 0) & (idx == 16'd0));
   endfunction

   lanes_t            vec_q [NUM_VEC];
   lanes_t            vec_d [NUM_VEC];
   logic [ELEM_W-1:0] sc_q  [NUM_SC];
   logic [ELEM_W-1:0] sc_d  [NUM_SC];
   lanes_t            wb_lanes;

   assign wb_lanes = wb_data;

   // Next-state storage: masked lane writes for vectors, lane 0 for scalars.
   always_comb begin
      vec_d = vec_q;
      sc_d  = sc_q;
      if (wb_valid && vec_impl(wb_addr)) begin
         for (int l = 0; l < LANES; l++) begin
            if (wb_mask[l]) begin
               vec_d[wb_addr[VIW-1:0]][l] = wb_lanes[l];
            end else begin
               vec_d[wb_addr[VIW-1:0]][l] = vec_q[wb_addr[VIW-1:0]][l];
            end
         end
      end else if (wb_valid && sc_impl(wb_addr) && wb_mask[0]) begin
         sc_d[wb_addr[SIW-1:0]] = wb_lanes[0];
      end else begin
         sc_d = sc_q;
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VEC; v++) begin
            vec_q[v] <= '0;
         end
         for (int s = 0; s < NUM_SC; s++) begin
            sc_q[s] <= '0;
         end
      end else begin
         vec_q <= vec_d;
         sc_q  <= sc_d;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [AW:0]       addr;
      logic              wb_match;
      logic [ELEM_W-1:0] sc_val;
      lanes_t            rd_word;

      assign addr = (p == 0) ? rd_addr1 : rd_addr2;

      // Operand mux: stored value, overridden per lane by a same-cycle writeback; scalars broadcast.
      always_comb begin
         wb_match = wb_valid && (wb_addr == addr);
         sc_val   = '0;
         rd_word  = '0;
         if (vec_impl(addr)) begin
            for (int l = 0; l < LANES; l++) begin
               rd_word[l] = (wb_match && wb_mask[l]) ? wb_lanes[l] : vec_q[addr[VIW-1:0]][l];
            end
         end else if (sc_impl(addr)) begin
            sc_val = (wb_match && wb_mask[0]) ? wb_lanes[0] : sc_q[addr[SIW-1:0]];
            for (int l = 0; l < LANES; l++) begin
               rd_word[l] = sc_val;
            end
         end else begin
            rd_word = '0;
         end
      end

      if (p == 0) begin : g_p0
         assign rd_data1 = rd_word;
      end else begin : g_p1
         assign rd_data2 = rd_word;
      end
   end

   rf_scoreboard #(
      .NUM_VEC (NUM_VEC),
      .NUM_SC  (NUM_SC),
      .SC_ZERO (SC_ZERO),
      .AW      (AW),
      .CNT_W   (CNT_W)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .rd_en1      (rd_en1),
      .rd_en2      (rd_en2),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rsv_valid   (rsv_valid),
      .rsv_addr    (rsv_addr),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .stall       (stall),
      .pending_cnt (pending_cnt),
      .wb_err      (wb_err)
   );

endmodule

// File: tb/tb_simd_reg_file_sb.sv
// Directed bench for simd_reg_file_sb with an address-indexed reference model checked every cycle.
module tb_simd_reg_file_sb;

   localparam int NUM_VEC = 8;
   localparam int NUM_SC  = 16;
   localparam int SC_ZERO = 1;

   localparam logic [4:0] V0 = 5'd0,  V1 = 5'd1,  V2 = 5'd2, V3 = 5'd3, V4 = 5'd4;
   localparam logic [4:0] V5 = 5'd5,  V6 = 5'd6,  V9 = 5'd9;
   localparam logic [4:0] S0 = 5'd16, S3 = 5'd19, S5 = 5'd21, S7 = 5'd23;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         rd_en1, rd_en2, rsv_valid, wb_valid;
   logic [4:0]   rd_addr1, rd_addr2, rsv_addr, wb_addr;
   logic [3:0]   wb_mask;
   logic [127:0] wb_data;
   logic [127:0] rd_data1, rd_data2;
   logic         stall, wb_err;
   logic [4:0]   pending_cnt;

   always #5 clk = ~clk;

   simd_reg_file_sb dut (
      .clk         (clk),
      .reset       (reset),
      .rd_en1      (rd_en1),
      .rd_en2      (rd_en2),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rd_data1    (rd_data1),
      .rd_data2    (rd_data2),
      .rsv_valid   (rsv_valid),
      .rsv_addr    (rsv_addr),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_mask     (wb_mask),
      .wb_data     (wb_data),
      .stall       (stall),
      .pending_cnt (pending_cnt),
      .wb_err      (wb_err)
   );

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (indexed by full 5-bit address) ----------------
   logic [31:0] m_val  [32][4];
   bit          m_busy [32];
   bit          m_err;

   function automatic bit m_impl(input logic [4:0] a);
      int idx;
      idx = int'(a[3:0]);
      if (a[4]) return (idx < NUM_SC) && !((SC_ZERO != 0) && (idx == 0));
      return idx < NUM_VEC;
   endfunction

   function automatic logic [127:0] m_read(input logic [4:0] a);
      logic [127:0] r;
      logic [31:0]  v;
      int           src;
      r = '0;
      if (!m_impl(a)) return r;
      for (int l = 0; l < 4; l++) begin
         src = a[4] ? 0 : l;
         v = m_val[a][src];
         if (wb_valid && (wb_addr == a) && wb_mask[src]) v = wb_data[src*32 +: 32];
         r[l*32 +: 32] = v;
      end
      return r;
   endfunction

   function automatic bit m_effbusy(input logic [4:0] a);
      return m_impl(a) && m_busy[a] && !(wb_valid && (wb_addr == a));
   endfunction

   function automatic bit m_stall();
      return (rd_en1 && m_effbusy(rd_addr1)) || (rd_en2 && m_effbusy(rd_addr2)) ||
             (rsv_valid && m_effbusy(rsv_addr));
   endfunction

   function automatic int m_count();
      int n;
      n = 0;
      for (int a = 0; a < 32; a++) n += int'(m_busy[a]);
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < 32; a++) begin
            m_busy[a] = 1'b0;
            for (int l = 0; l < 4; l++) m_val[a][l] = 32'd0;
         end
         m_err = 1'b0;
      end else begin
         bit acc;
         acc = rsv_valid && !m_stall() && m_impl(rsv_addr);
         m_err = wb_valid && !(m_impl(wb_addr) && m_busy[wb_addr]);
         if (wb_valid && m_impl(wb_addr)) begin
            for (int l = 0; l < 4; l++) begin
               if (wb_mask[l] && (!wb_addr[4] || l == 0)) m_val[wb_addr][l] = wb_data[l*32 +: 32];
            end
            m_busy[wb_addr] = 1'b0;
         end
         if (acc) m_busy[rsv_addr] = 1'b1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (run) begin
         check("cyc_rd_data1", rd_data1, m_read(rd_addr1));
         check("cyc_rd_data2", rd_data2, m_read(rd_addr2));
         check("cyc_stall", 128'(stall), 128'(m_stall()));
         check("cyc_pending_cnt", 128'(pending_cnt), 128'(m_count()));
         check("cyc_wb_err", 128'(wb_err), 128'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      rd_en1 = 1'b0; rd_en2 = 1'b0; rsv_valid = 1'b0; wb_valid = 1'b0;
      rd_addr1 = 5'd0; rd_addr2 = 5'd0; rsv_addr = 5'd0; wb_addr = 5'd0;
      wb_mask = 4'd0; wb_data = 128'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic rd1(input logic [4:0] a);
      rd_en1 = 1'b1; rd_addr1 = a;
   endtask

   task automatic rd2(input logic [4:0] a);
      rd_en2 = 1'b1; rd_addr2 = a;
   endtask

   task automatic rsv(input logic [4:0] a);
      rsv_valid = 1'b1; rsv_addr = a;
   endtask

   task automatic wb(input logic [4:0] a, input logic [3:0] m, input logic [127:0] d);
      wb_valid = 1'b1; wb_addr = a; wb_mask = m; wb_data = d;
   endtask

   initial begin
      idle();
      #1 reset = 1'b1;
      #2;
      rd1(V3); rd2(S5);
      #1;
      run = 1'b1;
      check("reset_rd_v3", rd_data1, 128'd0);
      check("reset_rd_s5", rd_data2, 128'd0);
      check("reset_stall", 128'(stall), 128'd0);
      check("reset_pending", 128'(pending_cnt), 128'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle();

      // Full then masked vector write, scalar write and broadcast.
      wb(V2, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1});
      next_cycle(); wb(V2, 4'b0101, {4{32'd9}}); settle();
      check("err_nonbusy_v2", 128'(wb_err), 128'd1);
      next_cycle(); rd1(V2); wb(S5, 4'b0001, 128'h55); settle();
      check("v2_masked", rd_data1, {32'd4, 32'd9, 32'd2, 32'd9});
      next_cycle(); rd2(S5); settle();
      check("s5_broadcast", rd_data2, {4{32'h55}});

      // Same-cycle bypass, lane-wise.
      next_cycle(); wb(V1, 4'b1111, {4{32'd1}});
      next_cycle(); wb(V1, 4'b0011, {32'd8, 32'd7, 32'd6, 32'd5}); rd1(V1); settle();
      check("bypass_v1", rd_data1, {32'd1, 32'd1, 32'd6, 32'd5});
      next_cycle(); rd1(V1); settle();
      check("v1_stored", rd_data1, {32'd1, 32'd1, 32'd6, 32'd5});

      // RAW on s7.
      next_cycle(); rsv(S7); settle();
      check("rsv_s7_nostall", 128'(stall), 128'd0);
      next_cycle(); rd1(S7); settle();
      check("raw_pending1", 128'(pending_cnt), 128'd1);
      check("raw_stall", 128'(stall), 128'd1);
      next_cycle(); rd1(S7); wb(S7, 4'b0001, 128'hAB); settle();
      check("raw_wb_nostall", 128'(stall), 128'd0);
      check("raw_wb_bypass", rd_data1, {4{32'hAB}});
      next_cycle(); settle();
      check("raw_pending0", 128'(pending_cnt), 128'd0);
      check("raw_no_err", 128'(wb_err), 128'd0);

      // WAW and same-edge reserve+writeback on v4.
      next_cycle(); rsv(V4);
      next_cycle(); rsv(V4); settle();
      check("waw_stall", 128'(stall), 128'd1);
      next_cycle(); settle();
      check("waw_pending_held", 128'(pending_cnt), 128'd1);
      next_cycle(); rsv(V4); wb(V4, 4'b1111, {4{32'hC4}}); settle();
      check("same_edge_nostall", 128'(stall), 128'd0);
      next_cycle(); rd1(V4); settle();
      check("same_edge_busy", 128'(stall), 128'd1);
      check("same_edge_pending", 128'(pending_cnt), 128'd1);
      check("same_edge_data", rd_data1, {4{32'hC4}});
      next_cycle(); wb(V4, 4'b0000, 128'd0);
      next_cycle(); rd1(V4); settle();
      check("mask0_clears_busy", 128'(stall), 128'd0);
      check("mask0_keeps_data", rd_data1, {4{32'hC4}});

      // Writeback to a non-busy register.
      next_cycle(); wb(V6, 4'b1111, {4{32'h66}});
      next_cycle(); rd1(V6); settle();
      check("v6_err", 128'(wb_err), 128'd1);
      check("v6_data", rd_data1, {4{32'h66}});
      next_cycle(); settle();
      check("v6_err_one_cycle", 128'(wb_err), 128'd0);

      // Hard-wired zero scalar register.
      next_cycle(); wb(S0, 4'b0001, 128'hFF); rd1(S0); settle();
      check("s0_bypass_zero", rd_data1, 128'd0);
      next_cycle(); rd1(S0); settle();
      check("s0_err", 128'(wb_err), 128'd1);
      check("s0_reads_zero", rd_data1, 128'd0);
      next_cycle(); rsv(S0);
      next_cycle(); rd1(S0); settle();
      check("s0_never_busy", 128'(stall), 128'd0);
      check("s0_no_count", 128'(pending_cnt), 128'd0);

      // Out-of-range vector index.
      next_cycle(); rsv(V9); wb(V9, 4'b1111, {4{32'h99}}); rd1(V9); settle();
      check("oor_read_zero", rd_data1, 128'd0);
      next_cycle(); rd1(V9); settle();
      check("oor_err", 128'(wb_err), 128'd1);
      check("oor_no_rsv", 128'(pending_cnt), 128'd0);

      // Asynchronous reset with three registers busy.
      next_cycle(); rsv(V0);
      next_cycle(); rsv(V5);
      next_cycle(); rsv(S3);
      next_cycle(); rd1(V2); rd2(S3); settle();
      check("pre_reset_pending3", 128'(pending_cnt), 128'd3);
      check("pre_reset_stall", 128'(stall), 128'd1);
      check("pre_reset_v2", rd_data1, {32'd4, 32'd9, 32'd2, 32'd9});
      reset = 1'b1;
      #1;
      check("async_reset_pending", 128'(pending_cnt), 128'd0);
      check("async_reset_stall", 128'(stall), 128'd0);
      check("async_reset_data", rd_data1, 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      next_cycle(); rd1(V5); rd2(S3); settle();
      check("post_reset_nostall", 128'(stall), 128'd0);
      next_cycle();
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
